// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, error
// codes and the image range check.
package imem_loader_pkg;

  localparam int MEM_MAX_SIZE_DEF = 1024;

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_HDR  = 3'd1,
    LD_DATA = 3'd2,
    LD_CSUM = 3'd3,
    LD_DONE = 3'd4,
    LD_ERR  = 3'd5
  } ld_state_e;

  typedef enum logic [1:0] {
    LERR_NONE = 2'd0,
    LERR_ADR  = 2'd1,
    LERR_CSUM = 2'd2
  } lerr_e;

  // 17-bit sum so base+len can never wrap past the memory end.
  function automatic logic range_bad(input logic [15:0] base, input logic [15:0] len,
                                     input logic [16:0] lim);
    logic [16:0] sum;
    sum = {1'b0, base} + {1'b0, len};
    return sum > lim;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the y86 instruction memory. Writes the image
// one byte per cycle and holds the CPU until a verified image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_MAX_SIZE = MEM_MAX_SIZE_DEF,
  parameter int AW           = 64
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          s_valid_i,
  input  logic [7:0]    s_data_i,
  output logic          s_ready_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_waddr_o,
  output logic [7:0]    mem_wdata_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [1:0]    err_o,
  output logic          cpu_hold_o
);

  localparam logic [16:0] LIM = 17'(MEM_MAX_SIZE);

  ld_state_e       state_q, state_d;
  logic [1:0]      hdr_cnt_q, hdr_cnt_d;
  logic [15:0]     base_q, base_d;
  logic [15:0]     len_q, len_d;
  logic [15:0]     rem_q, rem_d;
  logic [15:0]     off_q, off_d;
  logic [7:0]      csum_q, csum_d;
  logic            rbad_q, rbad_d;
  logic [1:0]      err_q, err_d;
  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [7:0]      wdata_q, wdata_d;

  logic            ready;
  logic            xfer;
  logic            start_ok;
  logic [15:0]     len_full;

  assign xfer     = s_valid_i & ready;
  assign start_ok = start_i & ((state_q == LD_IDLE) | (state_q == LD_DONE) |
                               (state_q == LD_ERR));
  // Length high byte arrives on the 4th header byte; decide with it directly.
  assign len_full = {s_data_i, len_q[7:0]};

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= LD_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE, LD_DONE, LD_ERR: if (start_i) state_d = LD_HDR;
      LD_HDR: begin
        if (xfer && hdr_cnt_q == 2'd3)
          state_d = (len_full == 16'd0) ? LD_CSUM : LD_DATA;
      end
      LD_DATA: if (xfer && rem_q == 16'd1) state_d = LD_CSUM;
      LD_CSUM: begin
        if (xfer)
          state_d = (rbad_q || s_data_i != csum_q) ? LD_ERR : LD_DONE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready      = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    cpu_hold_o = 1'b1;
    case (state_q)
      LD_HDR, LD_DATA, LD_CSUM: begin
        ready  = 1'b1;
        busy_o = 1'b1;
      end
      LD_DONE: begin
        done_o     = 1'b1;
        cpu_hold_o = 1'b0;
      end
      default: ;
    endcase
  end

  assign s_ready_o   = ready;
  assign err_o       = err_q;
  assign mem_we_o    = we_q;
  assign mem_waddr_o = waddr_q;
  assign mem_wdata_o = wdata_q;

  // Datapath next-state
  always_comb begin
    hdr_cnt_d = hdr_cnt_q;
    base_d    = base_q;
    len_d     = len_q;
    rem_d     = rem_q;
    off_d     = off_q;
    csum_d    = csum_q;
    rbad_d    = rbad_q;
    err_d     = err_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    if (start_ok) begin
      hdr_cnt_d = 2'd0;
      csum_d    = 8'h00;
      off_d     = 16'd0;
      rbad_d    = 1'b0;
      err_d     = LERR_NONE;
    end else if (xfer) begin
      case (state_q)
        LD_HDR: begin
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          case (hdr_cnt_q)
            2'd0: base_d[7:0]  = s_data_i;
            2'd1: base_d[15:8] = s_data_i;
            2'd2: len_d[7:0]   = s_data_i;
            default: begin
              len_d[15:8] = s_data_i;
              rem_d       = len_full;
              rbad_d      = range_bad(base_q, len_full, LIM);
            end
          endcase
        end
        LD_DATA: begin
          csum_d = csum_q ^ s_data_i;
          rem_d  = rem_q - 16'd1;
          off_d  = off_q + 16'd1;
          // Out-of-range frames are drained without touching memory.
          if (!rbad_q) begin
            we_d    = 1'b1;
            waddr_d = AW'(base_q) + AW'(off_q);
            wdata_d = s_data_i;
          end
        end
        LD_CSUM: begin
          if (rbad_q)                 err_d = LERR_ADR;
          else if (s_data_i != csum_q) err_d = LERR_CSUM;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hdr_cnt_q <= 2'd0;
      base_q    <= 16'd0;
      len_q     <= 16'd0;
      rem_q     <= 16'd0;
      off_q     <= 16'd0;
      csum_q    <= 8'h00;
      rbad_q    <= 1'b0;
      err_q     <= LERR_NONE;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= 8'h00;
    end else begin
      hdr_cnt_q <= hdr_cnt_d;
      base_q    <= base_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      off_q     <= off_d;
      csum_q    <= csum_d;
      rbad_q    <= rbad_d;
      err_q     <= err_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame-level model predicts writes (with
// timing) and final status; a per-cycle monitor compares the write port.
module tb_imem_loader;

  localparam int AW  = 64;
  localparam int MEM = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sv = 1'b0;
  logic [7:0]    sd = 8'h00;
  logic          s_ready, mem_we, busy, done, cpu_hold;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [1:0]    err;

  imem_loader #(.MEM_MAX_SIZE(MEM), .AW(AW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .s_valid_i(sv), .s_data_i(sd),
    .s_ready_o(s_ready), .mem_we_o(mem_we), .mem_waddr_o(mem_waddr),
    .mem_wdata_o(mem_wdata), .busy_o(busy), .done_o(done), .err_o(err),
    .cpu_hold_o(cpu_hold)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { longint addr; int data; int stamp; } wr_t;
  wr_t        expq[$];
  logic [7:0] pl[$];
  int         n_chk = 0, n_pass = 0;
  longint     last_waddr = -1;
  int         last_wdata = -1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [7:0] pl_xor();
    logic [7:0] x = 8'h00;
    foreach (pl[i]) x ^= pl[i];
    return x;
  endfunction

  // Per-cycle monitor: a write is due exactly one cycle after its byte is accepted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (expq.size() > 0 && expq[0].stamp <= cyc) begin
        chk("wr_we", longint'(mem_we), 1);
        chk("wr_addr", longint'(mem_waddr), expq[0].addr);
        chk("wr_data", longint'(mem_wdata), longint'(expq[0].data));
        void'(expq.pop_front());
      end else begin
        chk("no_wr", longint'(mem_we), 0);
      end
      if (mem_we) begin
        last_waddr = longint'(mem_waddr);
        last_wdata = int'(mem_wdata);
      end
      chk("hold_vs_done", longint'(cpu_hold), longint'(!done));
      chk("ready_vs_busy", longint'(s_ready), longint'(busy));
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, longint'(s_ready), 0);
    chk({tag, "_we"}, longint'(mem_we), 0);
    chk({tag, "_waddr"}, longint'(mem_waddr), 0);
    chk({tag, "_wdata"}, longint'(mem_wdata), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_err"}, longint'(err), 0);
    chk({tag, "_hold"}, longint'(cpu_hold), 1);
  endtask

  // Sends base/len/pl/csum. Called at a negedge; returns at a negedge.
  task automatic run_frame(input string tag, input int base, input int len,
                           input logic [7:0] csum, input bit gaps,
                           input int start_at, input int rst_after);
    logic [7:0] fb[$];
    bit   rbad;
    int   exp_err;
    rbad = (base + len) > MEM;
    fb.push_back(base[7:0]); fb.push_back(base[15:8]);
    fb.push_back(len[7:0]);  fb.push_back(len[15:8]);
    foreach (pl[k]) fb.push_back(pl[k]);
    fb.push_back(csum);
    start = 1'b1;
    for (int i = 0; i < fb.size(); i++) begin
      int t = 0;
      bit acc = 1'b0;
      if (gaps) while ($urandom_range(0, 2) == 0) begin
        sv = 1'b0; @(negedge clk); start = 1'b0;
      end
      sv = 1'b1; sd = fb[i];
      if (i == start_at) start = 1'b1;
      while (!acc && t < 50) begin
        acc = s_ready;
        if (acc && i >= 4 && i < 4 + len && !rbad)
          expq.push_back('{longint'(base + i - 4), int'(fb[i]), cyc + 1});
        @(negedge clk); start = 1'b0; t++;
      end
      if (!acc) begin chk({tag, "_accept_timeout"}, 0, 1); break; end
      if (i == rst_after) begin
        sv = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals({tag, "_midrst"});
        expq.delete();
        @(negedge clk); rst_n = 1'b1;
        return;
      end
    end
    sv = 1'b0;
    exp_err = rbad ? 1 : (csum != pl_xor()) ? 2 : 0;
    chk({tag, "_drained"}, longint'(expq.size()), 0);
    chk({tag, "_err"}, longint'(err), longint'(exp_err));
    chk({tag, "_done"}, longint'(done), longint'(exp_err == 0));
    chk({tag, "_hold"}, longint'(cpu_hold), longint'(exp_err != 0));
    chk({tag, "_busy"}, longint'(busy), 0);
    @(negedge clk);
  endtask

  initial begin
    #1 chk_reset_vals("por");
    repeat (3) @(negedge clk);
    chk_reset_vals("por_clk");
    rst_n = 1'b1;
    @(negedge clk);

    pl = '{8'h30, 8'hF2, 8'h0A};
    chk("model_xor_t1", longint'(pl_xor()), 'hC8);
    run_frame("t1", 'h0000, 3, 8'hC8, 1'b0, -1, -1);
    chk("t1_last_addr", last_waddr, 2);
    chk("t1_last_data", longint'(last_wdata), 'h0A);

    run_frame("t2", 'h0000, 3, 8'h00, 1'b0, -1, -1);
    chk("t2_err_lit", longint'(err), 2);

    pl = '{8'h11, 8'h22, 8'h33};
    last_waddr = -1;
    run_frame("t3", 'h03FE, 3, 8'h00, 1'b0, -1, -1);
    chk("t3_err_lit", longint'(err), 1);
    chk("t3_no_write", last_waddr, -1);

    pl = '{8'hA1, 8'hB2, 8'hC3};
    chk("model_xor_t4", longint'(pl_xor()), 'hD0);
    run_frame("t4", 'h03FD, 3, 8'hD0, 1'b0, -1, -1);
    chk("t4_last_addr", last_waddr, 'h3FF);
    chk("t4_last_data", longint'(last_wdata), 'hC3);

    pl.delete();
    run_frame("t5", 'h0040, 0, 8'h00, 1'b0, -1, -1);
    chk("t5_done_lit", longint'(done), 1);
    run_frame("t5b", 'h0040, 0, 8'h5A, 1'b0, -1, -1);
    chk("t5b_err_lit", longint'(err), 2);

    pl = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    run_frame("t6", 'h0100, 8, pl_xor(), 1'b1, -1, -1);
    chk("t6_last_addr", last_waddr, 'h107);

    pl = '{8'h5C, 8'h6D, 8'h7E, 8'h8F, 8'h90, 8'hA1};
    run_frame("t7", 'h0010, 6, pl_xor(), 1'b0, -1, 5);
    @(negedge clk);
    chk("t7_idle_busy", longint'(busy), 0);
    chk("t7_idle_ready", longint'(s_ready), 0);

    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h42};
    run_frame("t8", 'h0020, 5, pl_xor(), 1'b0, 6, -1);

    pl = '{8'h30, 8'hF2, 8'h0A};
    run_frame("t9", 'h0000, 3, 8'hC8, 1'b1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the y86 instruction memory: accepts a framed byte stream and writes the program image into instruction memory, one byte per cycle.
- The fetch stage reads the same memory 10 bytes at a time.
- Holds the CPU (cpu_hold_o) from reset until a complete, checksum-verified image has been written.
- Sits between the host/UART byte source and the instruction-memory write port.

Parameters:
- MEM_MAX_SIZE, 1024: instruction memory size in bytes; valid addresses are 0..MEM_MAX_SIZE-1.
- AW, 64: width of the memory write address, matching the fetch PC width.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle pulse that begins a load.
- s_valid_i  input  1  stream byte valid.
- s_data_i  input  8  stream byte.
- s_ready_o  output  1  loader can accept a byte; a byte transfers when s_valid_i and s_ready_o are both high.
- mem_we_o  output  1  memory byte write enable.
- mem_waddr_o  output  AW  memory byte address.
- mem_wdata_o  output  8  memory byte data.
- busy_o  output  1  load in progress.
- done_o  output  1  image loaded and verified (sticky).
- err_o  output  2  0 none, 1 address range, 2 checksum (sticky).
- cpu_hold_o  output  1  keep the pipeline stalled/reset.

Behaviour:
- Reset values (asynchronous):
  - state=IDLE.
  - s_ready_o=0, mem_we_o=0, mem_waddr_o=0, mem_wdata_o=0.
  - busy_o=0, done_o=0, err_o=0, cpu_hold_o=1.
  - All counters and the checksum are 0.
- Frame format, in byte order:
  - base address, 2 bytes, little-endian.
  - length L, 2 bytes, little-endian.
  - L payload bytes.
  - 1 checksum byte equal to the XOR of all payload bytes.
- States:
  - IDLE: s_ready_o=0. start_i -> HDR; clears done_o and err_o, sets busy_o, zeros the header counter and the checksum.
  - HDR: s_ready_o=1. Accepts 4 bytes into base[15:0] and len[15:0]. After the 4th byte:
    - If base+len > MEM_MAX_SIZE (17-bit compare, no wrap), set the internal range_bad flag.
    - If len==0, go to CSUM; otherwise go to DATA.
  - DATA: s_ready_o=1. For each accepted byte:
    - checksum ^= byte; remaining--.
    - If range_bad is clear, write the byte to address base+offset.
    - Leave DATA when the last byte (remaining==1) is accepted.
  - CSUM: s_ready_o=1. One byte is accepted.
    - If range_bad: -> ERR with err_o=1.
    - Else if the byte != checksum: -> ERR with err_o=2.
    - Else -> DONE.
  - DONE: busy_o=0, done_o=1, cpu_hold_o=0, s_ready_o=0.
  - ERR: busy_o=0, done_o=0, cpu_hold_o=1, s_ready_o=0.
  - From DONE or ERR, start_i -> HDR. cpu_hold_o returns to 1 on the same edge.
- Memory write port:
  - Registered, one-cycle latency: the byte accepted at edge N is presented on mem_we_o/mem_waddr_o/mem_wdata_o during the cycle after edge N, with mem_we_o=1.
  - mem_we_o is a single-cycle pulse per byte; back-to-back bytes give back-to-back writes.
  - Address is base zero-extended to AW, plus the payload offset.
  - On a range error no write is ever issued for that frame. The payload is still drained so the stream stays framed.
- Handshake:
  - s_ready_o depends only on state, never on s_valid_i.
  - Gaps in s_valid_i simply stall the FSM.
- Simultaneous events:
  - start_i while busy (HDR/DATA/CSUM) is ignored.
  - start_i in IDLE/DONE/ERR while s_valid_i is high does not consume that byte; the first byte is accepted on the next cycle.
- Boundaries:
  - base+len == MEM_MAX_SIZE is legal; the last write goes to MEM_MAX_SIZE-1.
  - L=0 with checksum 0x00 -> DONE; L=0 with any other checksum -> ERR, err_o=2.
- Reset mid-load:
  - Returns immediately to reset values, including cpu_hold_o=1.
  - Bytes already written stay in memory; the loader keeps no record of them.

Decomposition:
- Shared define.v entries:
  - State encodings LD_IDLE, LD_HDR, LD_DATA, LD_CSUM, LD_DONE, LD_ERR.
  - Error codes LERR_NONE=0, LERR_ADR=1, LERR_CSUM=2.
  - MEM_MAX_SIZE is shared with instr_memory.
- No sub-module; a single FSM plus datapath is natural.
- The top level connects mem_* to a write port added to instr_memory.

Test Plan:
- Reset, then start_i, then stream 00 00 03 00 30 F2 0A then checksum C8 -> writes (0,30),(1,F2),(2,0A) on consecutive cycles after acceptance; done_o=1, err_o=0, cpu_hold_o=0.
- Same frame with checksum 00 -> three writes occur, then ERR, err_o=2, cpu_hold_o=1, done_o=0.
- Base 0x03FE, L=3 (sum 1025 > 1024) -> mem_we_o never asserts; 3 payload bytes plus checksum consumed; err_o=1.
- Base 0x03FD, L=3 -> writes land at 0x3FD, 0x3FE, 0x3FF; done_o=1.
- L=0 with checksum 00 -> no writes, done_o=1.
- s_valid_i toggled randomly mid-payload -> write count and addresses unchanged, no byte dropped.
- rst_n_i pulsed low mid-DATA -> all outputs return to reset values within the same cycle.
- start_i pulsed during DATA -> ignored; the frame completes normally.
